// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM arbiter: FSM state encoding,
// error-counter width and the round-robin pointer wrap helper.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 32'd16;

    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_arbiter.sv
// Round-robin grant: the request vector is rotated so the pointer lands on
// bit 0, the lowest set bit wins, and the one-hot result is rotated back.
module rr_arbiter #(
    parameter int num_req = 2,
    parameter int idx_w   = 1
) (
    input  logic [num_req-1:0] req_i,
    input  logic [idx_w-1:0]   ptr_i,
    output logic [num_req-1:0] gnt_o
);

    logic [2*num_req-1:0] req_dbl_s;
    logic [num_req-1:0]   req_rot_s;
    logic [num_req-1:0]   gnt_rot_s;
    logic [2*num_req-1:0] gnt_dbl_s;
    logic                 hit_s;

    // rotate requests so the highest-priority requester sits at bit 0
    always_comb begin
        req_dbl_s = {req_i, req_i} >> ptr_i;
        req_rot_s = req_dbl_s[num_req-1:0];
    end

    // lowest set bit of the rotated vector wins
    always_comb begin
        gnt_rot_s = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < num_req; i++) begin
            if (req_rot_s[i] && !hit_s) begin
                gnt_rot_s[i] = 1'b1;
                hit_s        = 1'b1;
            end else begin
                gnt_rot_s[i] = 1'b0;
            end
        end
    end

    // rotate the grant back into requester numbering
    always_comb begin
        gnt_dbl_s = {gnt_rot_s, gnt_rot_s} << ptr_i;
        gnt_o     = gnt_dbl_s[2*num_req-1:num_req];
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates num_req read ports onto one combinational ROM, one transaction
// at a time (IDLE -> READ -> RESP). Define ROM_ARB_ERRCNT_EN to enable the
// saturating error-response counter on err_cnt_o; otherwise it reads 0.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int addr_width = 5,
    parameter int data_width = 16,
    parameter int num_req    = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [num_req-1:0]                   req_valid_i,
    input  logic [num_req-1:0][addr_width-1:0]   req_addr_i,
    output logic [num_req-1:0]                   req_ready_o,
    output logic [num_req-1:0]                   rsp_valid_o,
    output logic [data_width-1:0]                rsp_data_o,
    output logic                                 rsp_error_o,
    input  logic [num_req-1:0]                   rsp_ready_i,
    output logic [addr_width-1:0]                rom_addr_o,
    input  logic [data_width-1:0]                rom_data_i,
    input  logic                                 rom_error_i,
    output logic [CNT_W-1:0]                     err_cnt_o
);

    localparam int idx_w = (num_req > 1) ? $clog2(num_req) : 1;

    state_e                state_q, state_d;
    logic [idx_w-1:0]      ptr_q, ptr_d;
    logic [idx_w-1:0]      idx_q, idx_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic [num_req-1:0]    gnt_s;
    logic [idx_w-1:0]      gnt_idx_s;
    logic                  hs_s;
    logic                  rsp_done_s;

    rr_arbiter #(
        .num_req (num_req),
        .idx_w   (idx_w)
    ) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s)
    );

    // one-hot grant to index
    always_comb begin
        gnt_idx_s = '0;
        for (int i = 0; i < num_req; i++) begin
            gnt_idx_s = gnt_idx_s | (gnt_s[i] ? idx_w'(i) : '0);
        end
    end

    always_comb begin
        hs_s       = (state_q == ST_IDLE) && (|gnt_s);
        rsp_done_s = (state_q == ST_RESP) && rsp_ready_i[idx_q];
    end

    // next-state and transaction capture
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    state_d = ST_READ;
                    idx_d   = gnt_idx_s;
                    addr_d  = req_addr_i[gnt_idx_s];
                    ptr_d   = idx_w'(rr_wrap_inc(32'(gnt_idx_s), 32'(num_req)));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                data_d  = rom_data_i;
                err_d   = rom_error_i;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // rst_ni gates the combinational grant so ready is low while reset is held
    always_comb begin
        rsp_valid_o = '0;
        if ((state_q == ST_IDLE) && rst_ni) begin
            req_ready_o = gnt_s;
        end else begin
            req_ready_o = '0;
        end
        if (state_q == ST_READ) begin
            rom_addr_o = addr_q;
        end else begin
            rom_addr_o = '0;
        end
        if (state_q == ST_RESP) begin
            rsp_valid_o[idx_q] = 1'b1;
            rsp_data_o         = data_q;
            rsp_error_o        = err_q;
        end else begin
            rsp_data_o  = '0;
            rsp_error_o = 1'b0;
        end
    end

`ifdef ROM_ARB_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // saturating count of completed error responses
    always_comb begin
        if (rsp_done_s && err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // error counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_rom_arbiter;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NR = 2;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [NR-1:0]         req_valid_i;
    logic [NR-1:0][AW-1:0] req_addr_i;
    logic [NR-1:0]         req_ready_o;
    logic [NR-1:0]         rsp_valid_o;
    logic [DW-1:0]         rsp_data_o;
    logic                  rsp_error_o;
    logic [NR-1:0]         rsp_ready_i;
    logic [AW-1:0]         rom_addr_o;
    logic [DW-1:0]         rom_data_i;
    logic                  rom_error_i;
    logic [15:0]           err_cnt_o;

    logic [DW-1:0] rom_mem [32];
    logic          err_mem [32];

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    assign rom_data_i  = rom_mem[rom_addr_o];
    assign rom_error_i = err_mem[rom_addr_o];

    rom_arbiter #(.addr_width(AW), .data_width(DW), .num_req(NR)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_error_o (rsp_error_o),
        .rsp_ready_i (rsp_ready_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .rom_error_i (rom_error_i),
        .err_cnt_o   (err_cnt_o)
    );

    task automatic fill_rom();
        for (int i = 0; i < 32; i++) begin
            rom_mem[i] = 16'($urandom);
            err_mem[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        req_valid_i = 2'b11;
        req_addr_i  = '0;
        rsp_ready_i = 2'b00;
        #2;
        n_cmp++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready_o); end
        n_cmp++; if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
        n_cmp++; if (rom_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr_o); end
        n_cmp++; if (rsp_data_o !== 16'h0000 || rsp_error_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_data: got %h/%b want 0000/0", rsp_data_o, rsp_error_o); end
        n_cmp++; if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_o); end
        req_valid_i = 2'b00;
    endtask

    task automatic test_single();
        fill_rom();
        rom_mem[3] = 16'hBEEF;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        do_reset();
        req_valid_i   = 2'b01;
        req_addr_i[0] = 5'd3;
        @(negedge clk);
        n_cmp++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL single_ready_T: got %b want 01", req_ready_o); end
        @(posedge clk); #1 req_valid_i = 2'b00;
        @(negedge clk);
        n_cmp++; if (rom_addr_o !== 5'd3 || req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00) begin
            n_fail++; $display("FAIL single_read_T1: got addr %0d rdy %b vld %b want 3 00 00", rom_addr_o, req_ready_o, rsp_valid_o); end
        @(negedge clk);
        n_cmp++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== 16'hBEEF || rsp_error_o !== 1'b0 || rom_addr_o !== 5'd0) begin
            n_fail++; $display("FAIL single_rsp_T2: got vld %b data %h err %b addr %0d want 01 beef 0 0", rsp_valid_o, rsp_data_o, rsp_error_o, rom_addr_o); end
        @(negedge clk);
        n_cmp++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== 16'hBEEF) begin
            n_fail++; $display("FAIL single_hold: got vld %b data %h want 01 beef", rsp_valid_o, rsp_data_o); end
        rsp_ready_i = 2'b11;
        @(negedge clk);
        n_cmp++; if (rsp_valid_o !== 2'b00 || rsp_data_o !== 16'h0000) begin
            n_fail++; $display("FAIL single_done: got vld %b data %h want 00 0000", rsp_valid_o, rsp_data_o); end
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_contention();
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_vld;
        fill_rom();
        req_valid_i   = 2'b11;
        req_addr_i[0] = 5'($urandom);
        req_addr_i[1] = 5'($urandom);
        rsp_ready_i   = 2'b11;
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            exp_rdy = (cyc % 3 == 0) ? (((cyc / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_cmp++; if (req_ready_o !== exp_rdy) begin
                n_fail++; $display("FAIL contention_grant c%0d: got %b want %b", cyc, req_ready_o, exp_rdy); end
            if (cyc % 3 == 2) begin
                exp_vld = (((cyc / 3) % 2) == 0) ? 2'b01 : 2'b10;
                n_cmp++; if (rsp_valid_o !== exp_vld || rsp_data_o !== rom_mem[req_addr_i[((cyc / 3) % 2)]]) begin
                    n_fail++; $display("FAIL contention_rsp c%0d: got %b/%h want %b/%h", cyc, rsp_valid_o, rsp_data_o,
                                       exp_vld, rom_mem[req_addr_i[((cyc / 3) % 2)]]); end
            end
        end
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a;
        fill_rom();
        a = 5'($urandom);
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        do_reset();
        req_valid_i   = 2'b10;
        req_addr_i[1] = a;
        @(negedge clk);
        n_cmp++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL bp_grant: got %b want 10", req_ready_o); end
        @(posedge clk); #1;
        req_valid_i   = 2'b01;
        req_addr_i[0] = 5'($urandom);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid_o !== 2'b10 || rsp_data_o !== rom_mem[a] || req_ready_o !== 2'b00) begin
                n_fail++; $display("FAIL bp_stall%0d: got vld %b data %h rdy %b want 10 %h 00", k, rsp_valid_o, rsp_data_o, req_ready_o, rom_mem[a]); end
        end
        rsp_ready_i = 2'b10;
        @(negedge clk);
        n_cmp++; if (rsp_valid_o !== 2'b00 || req_ready_o !== 2'b01) begin
            n_fail++; $display("FAIL bp_release: got vld %b rdy %b want 00 01", rsp_valid_o, req_ready_o); end
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_error();
        logic [AW-1:0] a;
        fill_rom();
        a = 5'($urandom);
        err_mem[a] = 1'b1;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        do_reset();
        req_valid_i   = 2'b01;
        req_addr_i[0] = a;
        @(negedge clk);
        @(posedge clk); #1 req_valid_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (rsp_valid_o !== 2'b01 || rsp_error_o !== 1'b1 || err_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL err_rsp: got vld %b err %b cnt %0d want 01 1 0", rsp_valid_o, rsp_error_o, err_cnt_o); end
        rsp_ready_i = 2'b01;
`ifdef ROM_ARB_ERRCNT_EN
        exp_cnt = exp_cnt + 1;
`endif
        @(negedge clk);
        n_cmp++; if (err_cnt_o !== 16'(exp_cnt) || rsp_error_o !== 1'b0) begin
            n_fail++; $display("FAIL err_count: got cnt %0d err %b want %0d 0", err_cnt_o, rsp_error_o, exp_cnt); end
        rsp_ready_i = 2'b00;
        err_mem[a]  = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill_rom();
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        do_reset();
        req_valid_i   = 2'b01;
        req_addr_i[0] = 5'($urandom);
        req_addr_i[1] = 5'($urandom);
        @(negedge clk);
        @(posedge clk); #1 req_valid_i = 2'b11;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL mid_in_resp: got %b want 01", rsp_valid_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++; if (rsp_valid_o !== 2'b00 || rsp_data_o !== 16'h0000 || req_ready_o !== 2'b00 || err_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL mid_async_clear: got vld %b data %h rdy %b cnt %0d want 00 0000 00 0", rsp_valid_o, rsp_data_o, req_ready_o, err_cnt_o); end
        @(posedge clk); #1 rst_ni = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL mid_priority: got %b want 01", req_ready_o); end
        req_valid_i = 2'b00;
    endtask

    task automatic test_random();
        bit [NR-1:0]   pend;
        logic [AW-1:0] paddr [NR];
        int            last_g, phase, cur, win;
        logic [AW-1:0] cur_addr;
        logic [NR-1:0] e_rdy, e_vld;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_err;
        fill_rom();
        for (int i = 0; i < 32; i++) err_mem[i] = 1'($urandom);
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        do_reset();
        pend = '0; last_g = NR - 1; phase = 0; cur = 0; cur_addr = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && ($urandom_range(2) == 0)) begin
                    pend[i]  = 1'b1;
                    paddr[i] = 5'($urandom);
                end
                req_addr_i[i] = paddr[i];
            end
            req_valid_i = pend;
            rsp_ready_i = 2'($urandom);
            @(negedge clk);
            win = -1;
            for (int k = 1; k <= NR; k++) begin
                if (win < 0 && pend[(last_g + k) % NR]) win = (last_g + k) % NR;
            end
            e_rdy  = (phase == 0 && win >= 0) ? 2'(1 << win) : 2'b00;
            e_addr = (phase == 1) ? cur_addr : 5'd0;
            e_vld  = (phase >= 2) ? 2'(1 << cur) : 2'b00;
            e_data = (phase >= 2) ? rom_mem[cur_addr] : 16'h0000;
            e_err  = (phase >= 2) ? err_mem[cur_addr] : 1'b0;
            n_cmp++; if (req_ready_o !== e_rdy || rom_addr_o !== e_addr || rsp_valid_o !== e_vld ||
                         rsp_data_o !== e_data || rsp_error_o !== e_err || err_cnt_o !== 16'(exp_cnt)) begin
                n_fail++; $display("FAIL random c%0d: got rdy %b addr %0d vld %b data %h err %b cnt %0d want %b %0d %b %h %b %0d",
                                   cyc, req_ready_o, rom_addr_o, rsp_valid_o, rsp_data_o, rsp_error_o, err_cnt_o,
                                   e_rdy, e_addr, e_vld, e_data, e_err, exp_cnt); end
            if (phase == 0 && win >= 0) begin
                cur = win; cur_addr = paddr[win]; pend[win] = 1'b0; last_g = win; phase = 1;
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase >= 2 && rsp_ready_i[cur]) begin
`ifdef ROM_ARB_ERRCNT_EN
                if (err_mem[cur_addr] && exp_cnt < 65535) exp_cnt = exp_cnt + 1;
`endif
                phase = 0;
            end
        end
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
    endtask

    initial begin
        exp_cnt = 0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
